// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: default sizes,
// depth helper and the write-port arbitration used by both the array
// update and the read forwarding paths.
package rf_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 6;

  // Upper bounds for the arbitration helper; designs must stay within these.
  localparam int MAX_WR     = 16;
  localparam int MAX_ADDR_W = 16;

  typedef logic [MAX_ADDR_W-1:0]        addr_wide_t;
  typedef logic [MAX_WR-1:0]            we_wide_t;
  typedef logic [MAX_WR*MAX_ADDR_W-1:0] wa_wide_t;

  // Number of registers for a given address width.
  function automatic int rf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Index of the highest enabled write port targeting addr, or -1 if none.
  // Ports are packed at MAX_ADDR_W granularity; unused ports must have we=0.
  function automatic int win_port(input we_wide_t we_v, input wa_wide_t wa_v,
                                  input addr_wide_t addr);
    int win;
    win = -1;
    for (int k = 0; k < MAX_WR; k++) begin
      if (we_v[k] && (wa_v[k*MAX_ADDR_W +: MAX_ADDR_W] == addr)) win = k;
    end
    return win;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-bit scoreboard: one bit per register marking an outstanding writer.
// A same-cycle set beats a clear, and the per-port rd_pend view hides a bit
// that is being cleared by a write in the current cycle.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int N_RD     = 2,
  parameter int N_WR     = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [N_WR-1:0]        we_eff,
  input  logic [N_WR*ADDR_W-1:0] wa,
  input  logic [N_RD*ADDR_W-1:0] ra,
  input  logic                   pend_set,
  input  logic [ADDR_W-1:0]      pend_addr,
  output logic [N_RD-1:0]        rd_pend,
  output logic                   any_pend
);

  localparam int DEPTH = rf_depth(ADDR_W);

  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;
  logic             set_eff;

  // Next pending state: clears from enabled writes first, then the set overrides.
  always_comb begin
    set_eff = en && pend_set && !(ZERO_REG && (pend_addr == '0));
    pend_d  = pend_q;
    for (int k = 0; k < N_WR; k++) begin
      if (we_eff[k]) pend_d[wa[k*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (set_eff) pend_d[pend_addr] = 1'b1;
  end

  // Pending register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  // Per-read-port pending view, masked by a same-cycle clearing write.
  always_comb begin : rd_pend_view
    logic clear_hit;
    rd_pend  = '0;
    for (int j = 0; j < N_RD; j++) begin
      clear_hit = 1'b0;
      for (int k = 0; k < N_WR; k++) begin
        if (we_eff[k] && (wa[k*ADDR_W +: ADDR_W] == ra[j*ADDR_W +: ADDR_W])) clear_hit = 1'b1;
      end
      rd_pend[j] = pend_q[ra[j*ADDR_W +: ADDR_W]] &&
                   !(clear_hit && !(set_eff && (pend_addr == ra[j*ADDR_W +: ADDR_W])));
      if (rst || (ZERO_REG && (ra[j*ADDR_W +: ADDR_W] == '0))) rd_pend[j] = 1'b0;
    end
    any_pend = !rst && (|pend_q);
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: N_RD combinational read ports, N_WR synchronous
// write ports, same-cycle write forwarding, highest-port-wins conflicts,
// optional hardwired zero register and a pending-bit scoreboard.
module register_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int N_RD     = 2,
  parameter int N_WR     = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [N_WR-1:0]        we,
  input  logic [N_WR*ADDR_W-1:0] wa,
  input  logic [N_WR*DATA_W-1:0] wd,
  input  logic [N_RD*ADDR_W-1:0] ra,
  output logic [N_RD*DATA_W-1:0] rd,
  input  logic                   pend_set,
  input  logic [ADDR_W-1:0]      pend_addr,
  output logic [N_RD-1:0]        rd_pend,
  output logic                   any_pend
);

  localparam int DEPTH = rf_depth(ADDR_W);

  logic [N_WR-1:0] we_eff;
  we_wide_t        we_wide;
  wa_wide_t        wa_wide;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Qualify write ports with enable and the zero register, and widen for arbitration.
  always_comb begin
    we_eff  = '0;
    we_wide = '0;
    wa_wide = '0;
    for (int k = 0; k < N_WR; k++) begin
      we_eff[k]  = en && we[k] && !(ZERO_REG && (wa[k*ADDR_W +: ADDR_W] == '0));
      we_wide[k] = we_eff[k];
      wa_wide[k*MAX_ADDR_W +: MAX_ADDR_W] = MAX_ADDR_W'(wa[k*ADDR_W +: ADDR_W]);
    end
  end

  // Next array contents: only the winning port for each address writes.
  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < N_WR; k++) begin
      if (we_eff[k] &&
          (win_port(we_wide, wa_wide, wa_wide[k*MAX_ADDR_W +: MAX_ADDR_W]) == k))
        mem_d[wa[k*ADDR_W +: ADDR_W]] = wd[k*DATA_W +: DATA_W];
    end
  end

  // Register array with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read ports: stored value, overridden by the winning same-cycle write.
  always_comb begin : read_mux
    int w;
    rd = '0;
    for (int j = 0; j < N_RD; j++) begin
      w = win_port(we_wide, wa_wide, MAX_ADDR_W'(ra[j*ADDR_W +: ADDR_W]));
      rd[j*DATA_W +: DATA_W] = mem_q[ra[j*ADDR_W +: ADDR_W]];
      for (int k = 0; k < N_WR; k++) begin
        if (w == k) rd[j*DATA_W +: DATA_W] = wd[k*DATA_W +: DATA_W];
      end
      if (rst || (ZERO_REG && (ra[j*ADDR_W +: ADDR_W] == '0))) rd[j*DATA_W +: DATA_W] = '0;
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .N_RD     (N_RD),
    .N_WR     (N_WR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .we_eff    (we_eff),
    .wa        (wa),
    .ra        (ra),
    .pend_set  (pend_set),
    .pend_addr (pend_addr),
    .rd_pend   (rd_pend),
    .any_pend  (any_pend)
  );

endmodule

// File: tb/tb_register_file_mp.sv
// Directed testbench for register_file_mp (2 read, 2 write ports, zero register).
// A plain array model predicts reads, pending view and any_pend every cycle;
// literal checks pin the model at the interesting points.
module tb_register_file_mp;

  logic        clk = 1'b0;
  logic        rst, en, pend_set;
  logic [1:0]  we;
  logic [11:0] wa, ra;
  logic [63:0] wd, rd;
  logic [5:0]  pend_addr;
  logic [1:0]  rd_pend;
  logic        any_pend;

  logic [31:0] m_mem  [64];
  logic        m_pend [64];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  register_file_mp #(
    .DATA_W(32), .ADDR_W(6), .N_RD(2), .N_WR(2), .ZERO_REG(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd),
    .pend_set(pend_set), .pend_addr(pend_addr), .rd_pend(rd_pend), .any_pend(any_pend)
  );

  // Expected read data: later write ports override earlier ones, address 0 is always 0.
  function automatic logic [31:0] expRd(input logic [5:0] a);
    logic [31:0] v;
    if (rst || a == 6'd0) return 32'd0;
    v = m_mem[a];
    if (en && we[0] && wa[5:0]  == a) v = wd[31:0];
    if (en && we[1] && wa[11:6] == a) v = wd[63:32];
    return v;
  endfunction

  function automatic logic expPend(input logic [5:0] a);
    logic hit, set;
    if (rst || a == 6'd0) return 1'b0;
    hit = en && ((we[0] && wa[5:0] == a) || (we[1] && wa[11:6] == a));
    set = en && pend_set && pend_addr == a;
    if (hit && !set) return 1'b0;
    return m_pend[a];
  endfunction

  function automatic logic expAny();
    logic v;
    v = 1'b0;
    if (rst) return 1'b0;
    for (int i = 0; i < 64; i++) v = v | m_pend[i];
    return v;
  endfunction

  task automatic compare(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model for the current inputs.
  task automatic checkOutput();
    compare("rd0", {32'd0, rd[31:0]},  {32'd0, expRd(ra[5:0])});
    compare("rd1", {32'd0, rd[63:32]}, {32'd0, expRd(ra[11:6])});
    compare("rd_pend", {62'd0, rd_pend}, {62'd0, expPend(ra[11:6]), expPend(ra[5:0])});
    compare("any_pend", {63'd0, any_pend}, {63'd0, expAny()});
  endtask

  task automatic modelUpdate();
    if (rst) begin
      for (int i = 0; i < 64; i++) begin m_mem[i] = 32'd0; m_pend[i] = 1'b0; end
    end else if (en) begin
      if (we[0] && wa[5:0]  != 6'd0) begin m_mem[wa[5:0]]  = wd[31:0];  m_pend[wa[5:0]]  = 1'b0; end
      if (we[1] && wa[11:6] != 6'd0) begin m_mem[wa[11:6]] = wd[63:32]; m_pend[wa[11:6]] = 1'b0; end
      if (pend_set && pend_addr != 6'd0) m_pend[pend_addr] = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [1:0] w,
                               input logic [5:0] a0, input logic [31:0] d0,
                               input logic [5:0] a1, input logic [31:0] d1,
                               input logic [5:0] r0, input logic [5:0] r1,
                               input logic ps, input logic [5:0] pa);
    rst = r; en = e; we = w; wa = {a1, a0}; wd = {d1, d0};
    ra = {r1, r0}; pend_set = ps; pend_addr = pa;
    #1;
  endtask

  // Check current outputs, advance the model and the DUT by one clock.
  task automatic tick();
    checkOutput();
    modelUpdate();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin m_mem[i] = 32'd0; m_pend[i] = 1'b0; end
    rst = 1'b1; en = 1'b0; we = '0; wa = '0; wd = '0; ra = '0; pend_set = 1'b0; pend_addr = '0;
    @(negedge clk);

    // Reset cycle, then scan every address.
    applyStimulus(1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    compare("rst_rd", rd, 64'd0);
    tick();
    for (int a = 0; a < 64; a += 2) begin
      applyStimulus(0, 1, 2'b00, 0, 0, 0, 0, 6'(a), 6'(a + 1), 0, 0);
      compare("scan_rd", rd, 64'd0);
      compare("scan_any", {63'd0, any_pend}, 64'd0);
      tick();
    end

    // Write and read back.
    applyStimulus(0, 1, 2'b01, 1, 23, 0, 0, 5, 6, 0, 0);
    tick();
    applyStimulus(0, 1, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0);
    compare("readback_23", {32'd0, rd[31:0]}, 64'd23);
    tick();

    // Forwarding.
    applyStimulus(0, 1, 2'b01, 2, 5, 0, 0, 0, 2, 0, 0);
    compare("fwd_5", {32'd0, rd[63:32]}, 64'd5);
    tick();
    applyStimulus(0, 1, 2'b00, 0, 0, 0, 0, 0, 2, 0, 0);
    compare("stored_5", {32'd0, rd[63:32]}, 64'd5);
    tick();

    // Write conflict: port 1 wins.
    applyStimulus(0, 1, 2'b11, 7, 32'hAAAA, 7, 32'h5555, 7, 0, 0, 0);
    compare("conflict_fwd", {32'd0, rd[31:0]}, 64'h5555);
    tick();
    applyStimulus(0, 1, 2'b00, 0, 0, 0, 0, 7, 0, 0, 0);
    compare("conflict_store", {32'd0, rd[31:0]}, 64'h5555);
    tick();

    // Zero register.
    for (int c = 0; c < 2; c++) begin
      applyStimulus(0, 1, 2'b01, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 1, 0);
      compare("zero_rd", {32'd0, rd[31:0]}, 64'd0);
      compare("zero_pend", {62'd0, rd_pend}, 64'd0);
      compare("zero_any", {63'd0, any_pend}, 64'd0);
      tick();
    end

    // Scoreboard set then clear by write.
    applyStimulus(0, 1, 2'b00, 0, 0, 0, 0, 4, 0, 1, 4);
    tick();
    applyStimulus(0, 1, 2'b00, 0, 0, 0, 0, 4, 0, 0, 0);
    compare("pend4_set", {62'd0, rd_pend}, 64'd1);
    compare("any_set", {63'd0, any_pend}, 64'd1);
    tick();
    applyStimulus(0, 1, 2'b01, 4, 9, 0, 0, 4, 0, 0, 0);
    compare("pend4_clr_same", {62'd0, rd_pend}, 64'd0);
    compare("any_still", {63'd0, any_pend}, 64'd1);
    compare("fwd_9", {32'd0, rd[31:0]}, 64'd9);
    tick();
    applyStimulus(0, 1, 2'b00, 0, 0, 0, 0, 4, 0, 0, 0);
    compare("pend4_clr_after", {62'd0, rd_pend}, 64'd0);
    compare("any_fall", {63'd0, any_pend}, 64'd0);
    tick();

    // Set and clear together: set wins.
    applyStimulus(0, 1, 2'b00, 0, 0, 0, 0, 4, 0, 1, 4);
    tick();
    applyStimulus(0, 1, 2'b01, 4, 10, 0, 0, 4, 0, 1, 4);
    compare("setclr_same", {62'd0, rd_pend}, 64'd1);
    tick();
    applyStimulus(0, 1, 2'b00, 0, 0, 0, 0, 4, 0, 0, 0);
    compare("setclr_after", {62'd0, rd_pend}, 64'd1);
    compare("setclr_any", {63'd0, any_pend}, 64'd1);
    tick();
    applyStimulus(0, 1, 2'b10, 0, 0, 4, 10, 0, 4, 0, 0);
    tick();

    // Enable low: nothing takes effect, no forwarding.
    applyStimulus(0, 0, 2'b01, 3, 11, 0, 0, 3, 0, 1, 5);
    compare("en0_nofwd", {32'd0, rd[31:0]}, 64'd0);
    tick();
    applyStimulus(0, 1, 2'b00, 0, 0, 0, 0, 3, 5, 0, 0);
    compare("en0_hold", {32'd0, rd[31:0]}, 64'd0);
    compare("en0_nopend", {63'd0, any_pend}, 64'd0);
    tick();

    // Reset mid-operation discards the in-flight write and pend_set.
    applyStimulus(0, 1, 2'b01, 3, 11, 0, 0, 3, 0, 0, 0);
    compare("fwd_11", {32'd0, rd[31:0]}, 64'd11);
    tick();
    applyStimulus(0, 1, 2'b00, 0, 0, 0, 0, 3, 0, 1, 6);
    compare("stored_11", {32'd0, rd[31:0]}, 64'd11);
    tick();
    applyStimulus(1, 1, 2'b01, 3, 12, 0, 0, 3, 6, 1, 8);
    compare("rst_rd_mid", rd, 64'd0);
    compare("rst_any_mid", {63'd0, any_pend}, 64'd0);
    tick();
    applyStimulus(0, 1, 2'b00, 0, 0, 0, 0, 3, 6, 0, 0);
    compare("post_rst_rd", {32'd0, rd[31:0]}, 64'd0);
    compare("post_rst_pend", {62'd0, rd_pend}, 64'd0);
    compare("post_rst_any", {63'd0, any_pend}, 64'd0);
    tick();

    // Patterned traffic on both ports, checked against the model.
    for (int i = 0; i < 24; i++) begin
      logic [5:0] a0, a1;
      logic [1:0] w;
      a0 = 6'(i * 5 + 1);
      a1 = (i % 4 == 0) ? a0 : 6'(i * 11 + 3);
      w  = (i % 5 == 3) ? 2'b01 : (i % 5 == 4) ? 2'b10 : 2'b11;
      applyStimulus(0, (i % 7 != 6), w, a0, 32'h1000_0000 + 32'(i), a1,
                    32'hBEEF_0000 ^ 32'(i * 7), a0, 6'(i * 13), (i % 3 == 0), 6'(i * 7));
      tick();
    end

    // Final readback of the whole array via both ports.
    for (int a = 0; a < 64; a += 2) begin
      applyStimulus(0, 1, 2'b00, 0, 0, 0, 0, 6'(a), 6'(a + 1), 0, 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port successor to the processor's 2-read/1-write register file.
- Provides N_RD asynchronous read ports and N_WR synchronous write ports.
- Adds same-cycle write-to-read forwarding, deterministic write-conflict priority, an optional hardwired zero register and a per-register pending (scoreboard) bit for pipeline hazard checks.
- Sits between the decode stage (reads, pending checks) and the writeback stage (writes).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 6, address width; depth = 2**ADDR_W
- N_RD, 2, number of read ports
- N_WR, 2, number of write ports
- ZERO_REG, 1, 1: register 0 always reads 0 and ignores writes and pending sets

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  one clock; reset is synchronous and active-high
- en  in  1  global enable; when 0, no write, pending set or pending clear takes effect
- we  in  N_WR  write enable per write port
- wa  in  N_WR*ADDR_W  write addresses, port k at bits [k*ADDR_W +: ADDR_W]
- wd  in  N_WR*DATA_W  write data, port k at [k*DATA_W +: DATA_W]
- ra  in  N_RD*ADDR_W  read addresses, packed like wa
- rd  out  N_RD*DATA_W  read data, packed like wd
- pend_set  in  1  mark register pend_addr pending (an instruction was issued that will write it)
- pend_addr  in  ADDR_W  register to mark pending
- rd_pend  out  N_RD  pending bit for each read address, forwarded
- any_pend  out  1  OR of all pending bits

Behaviour:
- Reset: on the rising clk edge with rst=1, all registers and all pending bits clear to 0. This takes priority over en, we and pend_set. While rst is held, rd = 0, rd_pend = 0 and any_pend = 0.
- Writes: on each rising edge with en=1 and we[k]=1, reg[wa_k] <= wd_k.
- Write conflict: if two or more enabled ports target the same address in one cycle, the highest-index port wins. Lower ports to that address are dropped.
- Reads: combinational, zero latency. rd_j = reg[ra_j] in the base case.
- Forwarding: if en=1 and some enabled write port targets ra_j in the current cycle, rd_j shows that port's wd in the same cycle, using the same highest-index-wins rule. This makes a read during a write return the new value.
- Zero register (ZERO_REG=1):
  - Address 0 always reads 0.
  - Writes to address 0 are discarded and are not forwarded.
  - pend_set to address 0 is ignored, and rd_pend for address 0 is always 0.
- Pending bits:
  - Set: at the clock edge, pend[pend_addr] <= 1 when en=1 and pend_set=1.
  - Clear: at the clock edge, pend[wa_k] <= 0 for every enabled write port.
  - Set and clear on the same address in the same cycle: set wins. The newly issued writer is still outstanding.
- rd_pend_j: pend[ra_j], except it reads 0 if an enabled write to ra_j occurs this cycle and no same-cycle pend_set targets ra_j. any_pend is registered-state based (no forwarding).
- en=0: the array and pending bits hold. Reads still return stored contents, with no forwarding.
- Address range: full 2**ADDR_W space, so there are no out-of-range addresses and no wrap-around handling.
- Reset mid-operation: in-flight writes and pend_sets in the reset cycle are discarded.

Decomposition:
- Shared package rf_pkg holds:
  - default DATA_W and ADDR_W constants
  - a function computing depth from ADDR_W
  - a function returning the winning write-port index for an address (shared by the write and forwarding logic)
- One natural sub-module: rf_scoreboard, which holds the pending-bit array, set/clear priority, rd_pend and any_pend. The data array and forwarding stay in the top level.

Test Plan:
- Reset, write and read back:
  - Assert rst for 1 cycle, then read all addresses: expect rd = 0 and any_pend = 0.
  - Then write addr 1 = 23 via port 0; the next cycle ra0 = 1 gives 23.
- Forwarding:
  - In the same cycle, we[0]=1, wa0=2, wd0=5 and ra1=2: expect rd1 = 5 combinationally.
  - In the following cycle, with no write, rd1 still reads 5.
- Write conflict:
  - Port 0 writes addr 7 = 0xAAAA and port 1 writes addr 7 = 0x5555 in the same cycle: expect forwarded and stored value 0x5555.
- Zero register:
  - Write addr 0 = 0xFFFF_FFFF with pend_set to addr 0: rd from addr 0 is 0 in the same and next cycle; rd_pend = 0 and any_pend = 0.
- Scoreboard:
  - pend_set addr 4, then ra0 = 4: expect rd_pend[0] = 1 and any_pend = 1.
  - Write addr 4 = 9: rd_pend[0] = 0 in that cycle and afterwards, and any_pend falls to 0 the next cycle.
  - Repeat with pend_set to addr 4 in the same cycle as the write: the bit stays 1.
- Enable and reset mid-operation:
  - With en=0, write addr 3 = 11: the stored value stays 0.
  - Write addr 3 = 11 with en=1, then assert rst together with a write of addr 3 = 12: after reset, addr 3 reads 0 and no pending bits are set.
